ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
Instruction fetch stage directly upstream of the single-cycle core; it produces the core's `instr` input.
- Owns the fetch PC.
- Issues one read at a time to instruction memory over a valid/ready request/response pair.
- Presents each returned word with its PC to the core over a valid/ready output channel.
- Accepts PC redirects (branch/jump targets) from execute and discards wrong-path fetches.

Parameters:
RESET_PC, 32'h80000000, fetch PC loaded on reset
XLEN, 32, address/data width

Ports:
clk  in  1  clock, all state rising-edge
rst  in  1  asynchronous, active-low reset (0 = reset)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_resp_valid  in  1  read data valid
imem_resp_ready  out  1  IFU accepts response
imem_resp_data  in  XLEN  instruction word
imem_resp_err  in  1  bus error on this fetch
inst_valid  out  1  instruction available to core
inst_ready  in  1  core consumes instruction
inst  out  XLEN  instruction word
inst_pc  out  XLEN  PC of inst
inst_fault  out  1  fetch fault flag for inst
redirect_valid  in  1  execute redirects fetch
redirect_pc  in  XLEN  redirect target

Behaviour:
- Reset (rst=0, async):
  - state=REQ, pc=RESET_PC, redir_pend=0.
  - All valid/ready outputs 0; inst, inst_pc, inst_fault = 0.
- Memory shares the reset, so no pre-reset response can arrive afterwards.
- FSM states: REQ, WAIT, OUT.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - valid and addr are held stable until imem_req_ready=1; the request is never withdrawn.
  - On handshake -> WAIT.
- WAIT:
  - imem_resp_ready=1.
  - On imem_resp_valid with redir_pend=0: latch data into inst, err into inst_fault, pc into inst_pc -> OUT.
  - On imem_resp_valid with redir_pend=1 (or redirect_valid same cycle): response dropped; pc<=target; redir_pend<=0 -> REQ.
- OUT:
  - inst_valid = (state==OUT) && !redirect_valid. A redirect masks valid combinationally, so a wrong-path instruction is never consumed.
  - inst_valid && inst_ready: pc<=pc+4 -> REQ.
  - redirect_valid: pc<=redirect_pc -> REQ; the held instruction is discarded.
  - inst/inst_pc/inst_fault stay stable while inst_valid=1 and inst_ready=0.
- Redirect in REQ or WAIT: redirect_pc is stored in redir_pc and redir_pend<=1. The in-flight transaction completes on the bus, then its response is dropped.
- A second redirect before the pending one is applied overwrites redir_pc (newest wins).
- Redirect in REQ on the same cycle as the request handshake: the request is marked stale (redir_pend=1).
- Latency: output is valid no earlier than 2 cycles after entering REQ, with zero-wait memory (REQ, WAIT, OUT). Throughput is at most 1 instruction per 3 cycles.
- pc+4 wraps modulo 2^XLEN (0xFFFFFFFC -> 0x00000000) with no flag.
- imem_resp_err=1: inst=imem_resp_data (unspecified), inst_fault=1; flow otherwise identical.
- Reset asserted mid-transaction: immediate return to reset values; no response is consumed.

Optional Feature:
IFU_MISALIGN_CHECK_EN
- Defined: if pc[1:0]!=0 when entering REQ, no bus request is issued. Next cycle -> OUT with inst=32'h0, inst_fault=1, inst_pc=pc.
- Undefined: redirect_pc[1:0] is forced to 2'b00 when captured, and no misalign fault exists.

Decomposition:
- Shared package ifu_pkg:
  - state enum {REQ, WAIT, OUT}, 2-bit encoding.
  - RESET_PC default constant.
  - NOP constant 32'h00000013, used by the core on fault.
- One natural sub-module, ifu_redirect_latch: holds redir_pend/redir_pc, with set/overwrite/clear and async active-low reset.
- FSM, PC and output registers stay in ifu_fetch.

Test Plan:
- Release reset, memory always ready, 0-wait, returns addr^0xA5A5A5A5, core always ready -> inst_pc sequence 0x80000000, 0x80000004, 0x80000008; one inst per 3 cycles; data matches.
- Core holds inst_ready=0 for 5 cycles in OUT -> inst/inst_pc/inst_fault stable; no new imem request; pc advances only after the handshake.
- redirect_valid to 0x80000100 while in WAIT with 3-cycle response latency -> that response dropped; next imem_req_addr=0x80000100; no inst_valid for the stale word.
- redirect_valid to 0x80000200 in OUT while inst_ready=1 -> inst_valid=0 that cycle, no handshake; next request addr 0x80000200.
- Two redirects (0x100, then 0x200) during a single WAIT -> only 0x200 fetched.
- imem_resp_err=1 at 0x80000004 -> inst_fault=1, inst_pc=0x80000004; next fetch 0x80000008.
- Assert rst=0 mid-WAIT -> outputs zero immediately; after release, first request addr=RESET_PC.
- With IFU_MISALIGN_CHECK_EN, redirect to 0x80000102 -> no bus request; inst_fault=1, inst_pc=0x80000102.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   localparam int unsigned IFU_XLEN     = 32;
   localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
   localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_OUT  = 2'd2
   } ifu_state_e;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return (lsb != 2'b00);
   endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, core output
// channel and the redirect input from execute. master = fetch unit side.
interface ifu_fetch_if
   import ifu_pkg::*;
#(
   parameter int unsigned XLEN = IFU_XLEN
) ();

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic            imem_resp_ready;
   logic [XLEN-1:0] imem_resp_data;
   logic            imem_resp_err;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] inst_pc;
   logic            inst_fault;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output imem_req_valid, imem_req_addr, imem_resp_ready,
      output inst_valid, inst, inst_pc, inst_fault,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
      input  inst_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, imem_resp_ready,
      input  inst_valid, inst, inst_pc, inst_fault,
      output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
      output inst_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/ifu_redirect_latch.sv
// Holds a redirect target that arrived while a fetch was in flight.
// A new set overwrites the stored target (newest wins); set beats clear.
module ifu_redirect_latch
   import ifu_pkg::*;
#(
   parameter int unsigned XLEN = IFU_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set_i,
   input  logic [XLEN-1:0] set_pc_i,
   input  logic            clr_i,
   output logic            pend_o,
   output logic [XLEN-1:0] pc_o
);

   logic            pend_q;
   logic            pend_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   always_comb begin
      pend_d = pend_q;
      pc_d   = pc_q;
      if (set_i) begin
         pend_d = 1'b1;
         pc_d   = set_pc_i;
      end else if (clr_i) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q <= 1'b0;
         pc_q   <= {XLEN{1'b0}};
      end else begin
         pend_q <= pend_d;
         pc_q   <= pc_d;
      end
   end

   assign pend_o = pend_q;
   assign pc_o   = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem read, valid/ready output to the core,
// redirect handling. Optional IFU_MISALIGN_CHECK_EN faults misaligned PCs instead of masking them.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter int unsigned     XLEN     = IFU_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   ifu_fetch_if.master bus
);

   ifu_state_e      state_q;
   ifu_state_e      state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] inst_q;
   logic [XLEN-1:0] inst_d;
   logic [XLEN-1:0] inst_pc_q;
   logic [XLEN-1:0] inst_pc_d;
   logic            fault_q;
   logic            fault_d;

   logic            redir_set_s;
   logic            redir_clr_s;
   logic            redir_pend_s;
   logic [XLEN-1:0] redir_pc_s;
   logic [XLEN-1:0] rpc_cap_s;
   logic            misalign_s;

`ifdef IFU_MISALIGN_CHECK_EN
   assign rpc_cap_s  = bus.redirect_pc;
   assign misalign_s = is_misaligned(pc_q[1:0]);
`else
   assign rpc_cap_s  = {bus.redirect_pc[XLEN-1:2], 2'b00};
   assign misalign_s = 1'b0;
`endif

   ifu_redirect_latch #(.XLEN(XLEN)) u_redir (
      .clk      (clk),
      .rst      (rst),
      .set_i    (redir_set_s),
      .set_pc_i (rpc_cap_s),
      .clr_i    (redir_clr_s),
      .pend_o   (redir_pend_s),
      .pc_o     (redir_pc_s)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_REQ;
         pc_q      <= RESET_PC;
         inst_q    <= {XLEN{1'b0}};
         inst_pc_q <= {XLEN{1'b0}};
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         fault_q   <= fault_d;
      end
   end

   // A response that arrives with a redirect pending (or arriving) is wrong-path and dropped.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_d      = inst_q;
      inst_pc_d   = inst_pc_q;
      fault_d     = fault_q;
      redir_set_s = 1'b0;
      redir_clr_s = 1'b0;
      case (state_q)
         ST_REQ: begin
            if (misalign_s) begin
               if (bus.redirect_valid) begin
                  pc_d = rpc_cap_s;
               end else begin
                  state_d   = ST_OUT;
                  inst_d    = {XLEN{1'b0}};
                  inst_pc_d = pc_q;
                  fault_d   = 1'b1;
               end
            end else begin
               redir_set_s = bus.redirect_valid;
               if (bus.imem_req_ready) begin
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_WAIT: begin
            if (bus.imem_resp_valid) begin
               if (bus.redirect_valid || redir_pend_s) begin
                  pc_d        = bus.redirect_valid ? rpc_cap_s : redir_pc_s;
                  redir_clr_s = 1'b1;
                  state_d     = ST_REQ;
               end else begin
                  inst_d    = bus.imem_resp_data;
                  inst_pc_d = pc_q;
                  fault_d   = bus.imem_resp_err;
                  state_d   = ST_OUT;
               end
            end else begin
               redir_set_s = bus.redirect_valid;
            end
         end
         ST_OUT: begin
            if (bus.redirect_valid) begin
               pc_d    = rpc_cap_s;
               state_d = ST_REQ;
            end else if (bus.inst_ready) begin
               pc_d    = pc_q + XLEN'(32'd4);
               state_d = ST_REQ;
            end else begin
               state_d = ST_OUT;
            end
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   // Request valid is gated by reset because the reset state is REQ.
   always_comb begin
      bus.imem_req_valid  = 1'b0;
      bus.imem_resp_ready = 1'b0;
      bus.inst_valid      = 1'b0;
      case (state_q)
         ST_REQ:  bus.imem_req_valid  = rst && !misalign_s;
         ST_WAIT: bus.imem_resp_ready = 1'b1;
         ST_OUT:  bus.inst_valid      = !bus.redirect_valid;
         default: bus.imem_req_valid  = 1'b0;
      endcase
   end

   assign bus.imem_req_addr = pc_q;
   assign bus.inst          = inst_q;
   assign bus.inst_pc       = inst_pc_q;
   assign bus.inst_fault    = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: queued expected requests/instructions, a memory
// model returning addr^0xA5A5A5A5, and directed redirect/stall/reset/fault scenarios.
module tb_ifu_fetch;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      logic        fault;
      logic        chk_data;
   } exp_t;

   exp_t        exp_inst[$];
   logic [31:0] exp_req[$];
   int          hs_cyc[$];
   int          inst_hs_cnt = 0;
   int          hs_base = 0;

   int          mem_lat = 0;
   logic        err_en = 1'b0;
   logic [31:0] err_addr = 32'h8000_0004;
   logic        mem_busy = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = 32'h0;
   logic        s_req_hs;
   logic        s_resp_hs;
   logic [31:0] s_addr;

   ifu_fetch_if #(.XLEN(32)) bus_if ();

   ifu_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_inst(input logic [31:0] pc, input logic fault, input logic chk, input logic [31:0] data);
      exp_t e;
      e.pc = pc; e.fault = fault; e.chk_data = chk; e.data = data;
      exp_inst.push_back(e);
   endtask

   task automatic wait_hs(input int n, input string name);
      int k = 0;
      while (inst_hs_cnt < n && k < 300) begin tick(); k++; end
      check32(name, inst_hs_cnt, n);
   endtask

   task automatic wait_valid(input string name);
      int k = 0;
      while (!bus_if.inst_valid && k < 300) begin tick(); k++; end
      check32(name, {31'd0, bus_if.inst_valid}, 32'd1);
   endtask

   task automatic wait_wait(input logic [31:0] addr, input string name);
      int k = 0;
      while (!(bus_if.imem_resp_ready && bus_if.imem_req_addr == addr) && k < 300) begin tick(); k++; end
      check32(name, {31'd0, bus_if.imem_resp_ready}, 32'd1);
   endtask

   task automatic redirect(input logic [31:0] pc);
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = pc;
      tick();
      bus_if.redirect_valid = 1'b0;
   endtask

   // memory model: sample at negedge, respond after the following posedge
   initial begin
      bus_if.imem_req_ready  = 1'b1;
      bus_if.imem_resp_valid = 1'b0;
      bus_if.imem_resp_data  = 32'h0;
      bus_if.imem_resp_err   = 1'b0;
      forever begin
         @(negedge clk);
         s_req_hs  = bus_if.imem_req_valid && bus_if.imem_req_ready;
         s_resp_hs = bus_if.imem_resp_valid && bus_if.imem_resp_ready;
         s_addr    = bus_if.imem_req_addr;
         tick();
         if (!rst) begin
            bus_if.imem_resp_valid = 1'b0;
            mem_busy = 1'b0;
         end else begin
            if (s_resp_hs) bus_if.imem_resp_valid = 1'b0;
            if (s_req_hs) begin
               mem_busy = 1'b1; mem_addr = s_addr; mem_cnt = mem_lat;
            end else if (mem_busy && mem_cnt > 0) begin
               mem_cnt--;
            end
            if (mem_busy && mem_cnt == 0) begin
               bus_if.imem_resp_valid = 1'b1;
               bus_if.imem_resp_data  = mem_addr ^ 32'hA5A5_A5A5;
               bus_if.imem_resp_err   = err_en && (mem_addr == err_addr);
               mem_busy = 1'b0;
            end
         end
      end
   end

   // monitor: compares every request and instruction handshake against the queues
   initial begin
      exp_t e;
      logic [31:0] a;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (bus_if.imem_req_valid && bus_if.imem_req_ready) begin
               if (exp_req.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL req_unexpected: got addr %08h expected no request", bus_if.imem_req_addr);
               end else begin
                  a = exp_req.pop_front();
                  check32("req_addr", bus_if.imem_req_addr, a);
               end
            end
            if (bus_if.inst_valid && bus_if.inst_ready) begin
               inst_hs_cnt++;
               hs_cyc.push_back(cyc);
               if (exp_inst.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL inst_unexpected: got pc %08h expected no instruction", bus_if.inst_pc);
               end else begin
                  e = exp_inst.pop_front();
                  check32("inst_pc", bus_if.inst_pc, e.pc);
                  check32("inst_fault", {31'd0, bus_if.inst_fault}, {31'd0, e.fault});
                  if (e.chk_data) check32("inst_data", bus_if.inst, e.data);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_if.inst_ready     = 1'b1;
      bus_if.redirect_valid = 1'b0;
      bus_if.redirect_pc    = 32'h0;
      repeat (3) tick();
      check32("rst_req_valid",  {31'd0, bus_if.imem_req_valid},  32'd0);
      check32("rst_resp_ready", {31'd0, bus_if.imem_resp_ready}, 32'd0);
      check32("rst_inst_valid", {31'd0, bus_if.inst_valid},      32'd0);
      check32("rst_inst",       bus_if.inst,                     32'd0);
      check32("rst_inst_pc",    bus_if.inst_pc,                  32'd0);

      // streaming, zero-wait memory
      for (int i = 0; i < 4; i++) exp_req.push_back(32'h8000_0000 + 32'(i * 4));
      for (int i = 0; i < 3; i++) push_inst(32'h8000_0000 + 32'(i * 4), 1'b0, 1'b1, (32'h8000_0000 + 32'(i * 4)) ^ 32'hA5A5_A5A5);
      rst = 1'b1;
      wait_hs(3, "p1_stream");
      bus_if.inst_ready = 1'b0;
      if (hs_cyc.size() >= 3) begin
         check32("p1_rate_a", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
         check32("p1_rate_b", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
      end else begin
         check32("p1_rate_cnt", 32'(hs_cyc.size()), 32'd3);
      end

      // core stall in OUT
      push_inst(32'h8000_000C, 1'b0, 1'b1, 32'h8000_000C ^ 32'hA5A5_A5A5);
      exp_req.push_back(32'h8000_0010);
      wait_valid("p2_valid");
      for (int i = 0; i < 5; i++) begin
         check32("p2_hold_inst",  bus_if.inst,    32'h8000_000C ^ 32'hA5A5_A5A5);
         check32("p2_hold_pc",    bus_if.inst_pc, 32'h8000_000C);
         check32("p2_no_req",     {31'd0, bus_if.imem_req_valid}, 32'd0);
         tick();
      end
      mem_lat = 3;
      bus_if.inst_ready = 1'b1;

      // redirect during WAIT with slow memory
      wait_wait(32'h8000_0010, "p3_wait");
      exp_req.push_back(32'h8000_0100);
      redirect(32'h8000_0100);
      bus_if.inst_ready = 1'b0;
      wait_valid("p3_valid");
      check32("p3_no_stale", bus_if.inst_pc, 32'h8000_0100);

      // redirect in OUT while core ready: held word discarded
      exp_req.push_back(32'h8000_0200);
      bus_if.inst_ready     = 1'b1;
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = 32'h8000_0200;
      #1;
      check32("p4_mask", {31'd0, bus_if.inst_valid}, 32'd0);
      tick();
      bus_if.redirect_valid = 1'b0;
      push_inst(32'h8000_0200, 1'b0, 1'b1, 32'h8000_0200 ^ 32'hA5A5_A5A5);
      exp_req.push_back(32'h8000_0204);

      // two redirects in one WAIT: newest wins
      wait_wait(32'h8000_0204, "p5_wait");
      exp_req.push_back(32'h8000_0200);
      push_inst(32'h8000_0200, 1'b0, 1'b1, 32'h8000_0200 ^ 32'hA5A5_A5A5);
      exp_req.push_back(32'h8000_0204);
      redirect(32'h8000_0100);
      redirect(32'h8000_0200);
      wait_hs(6, "p5_stream");

      // reset mid-WAIT
      wait_wait(32'h8000_0204, "p7_wait");
      rst = 1'b0;
      #1;
      check32("p7_req_valid",  {31'd0, bus_if.imem_req_valid},  32'd0);
      check32("p7_resp_ready", {31'd0, bus_if.imem_resp_ready}, 32'd0);
      check32("p7_inst_valid", {31'd0, bus_if.inst_valid},      32'd0);
      check32("p7_inst",       bus_if.inst,                     32'd0);
      check32("p7_inst_pc",    bus_if.inst_pc,                  32'd0);
      check32("p7_fault",      {31'd0, bus_if.inst_fault},      32'd0);
      repeat (3) tick();
      check32("p7_req_q_empty",  32'(exp_req.size()),  32'd0);
      check32("p7_inst_q_empty", 32'(exp_inst.size()), 32'd0);

      // bus error at 0x80000004 after reset release
      mem_lat = 0;
      err_en  = 1'b1;
      bus_if.inst_ready = 1'b1;
      hs_base = inst_hs_cnt;
      exp_req.push_back(32'h8000_0000);
      exp_req.push_back(32'h8000_0004);
      exp_req.push_back(32'h8000_0008);
      push_inst(32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000 ^ 32'hA5A5_A5A5);
      push_inst(32'h8000_0004, 1'b1, 1'b0, 32'h0);
      rst = 1'b1;
      wait_hs(hs_base + 2, "p6_stream");
      bus_if.inst_ready = 1'b0;
      wait_valid("p6_valid");
      check32("p6_next_pc",    bus_if.inst_pc, 32'h8000_0008);
      check32("p6_next_fault", {31'd0, bus_if.inst_fault}, 32'd0);

      // pc+4 wraps to zero
      exp_req.push_back(32'hFFFF_FFFC);
      push_inst(32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC ^ 32'hA5A5_A5A5);
      exp_req.push_back(32'h0000_0000);
      redirect(32'hFFFF_FFFC);
      bus_if.inst_ready = 1'b1;
      wait_hs(hs_base + 3, "wrap_stream");
      bus_if.inst_ready = 1'b0;
      wait_valid("wrap_valid");
      check32("wrap_pc", bus_if.inst_pc, 32'h0000_0000);

      // misaligned redirect target
`ifdef IFU_MISALIGN_CHECK_EN
      push_inst(32'h8000_0102, 1'b1, 1'b1, 32'h0);
      redirect(32'h8000_0102);
      wait_valid("mis_valid");
      check32("mis_pc",    bus_if.inst_pc, 32'h8000_0102);
      check32("mis_fault", {31'd0, bus_if.inst_fault}, 32'd1);
`else
      exp_req.push_back(32'h8000_0100);
      push_inst(32'h8000_0100, 1'b0, 1'b1, 32'h8000_0100 ^ 32'hA5A5_A5A5);
      exp_req.push_back(32'h8000_0104);
      redirect(32'h8000_0102);
      wait_valid("mis_valid");
      check32("mis_pc",    bus_if.inst_pc, 32'h8000_0100);
      check32("mis_fault", {31'd0, bus_if.inst_fault}, 32'd0);
`endif
      bus_if.inst_ready = 1'b1;
      wait_hs(hs_base + 4, "mis_consume");
      bus_if.inst_ready = 1'b0;
      repeat (12) tick();
      check32("end_req_q_empty",  32'(exp_req.size()),  32'd0);
      check32("end_inst_q_empty", 32'(exp_inst.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
